// File: rtl/draw_scheduler_if.sv
// Request, copy-engine and VGA signal bundle for draw_scheduler.
// The master side is game logic plus the copy engine; the slave side is the scheduler.
interface draw_scheduler_if;
  logic        screen_req;
  logic [1:0]  screen_sel;
  logic        tile_req;
  logic [3:0]  tile_id;
  logic [4:0]  tile_col;
  logic [3:0]  tile_row;
  logic        tile_ready;
  logic        tile_drop;
  logic        screen_ack;
  logic        done;
  logic        busy;
  logic        copy_go;
  logic [1:0]  copy_memory_select;
  logic [3:0]  copy_tile_select;
  logic [16:0] copy_offset;
  logic [2:0]  copy_colour;
  logic        copy_write_en;
  logic        copy_finished;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  modport master (
    output screen_req, screen_sel, tile_req, tile_id, tile_col, tile_row,
    output copy_offset, copy_colour, copy_write_en, copy_finished,
    input  tile_ready, tile_drop, screen_ack, done, busy,
    input  copy_go, copy_memory_select, copy_tile_select,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  screen_req, screen_sel, tile_req, tile_id, tile_col, tile_row,
    input  copy_offset, copy_colour, copy_write_en, copy_finished,
    output tile_ready, tile_drop, screen_ack, done, busy,
    output copy_go, copy_memory_select, copy_tile_select,
    output vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/draw_scheduler.sv
// Schedules full-screen and tile copy jobs onto the copy engine and maps its offsets to VGA x/y.
// Optional: define DRAW_SCHED_FLUSH_EN to empty the tile queue whenever a screen job is issued.
module draw_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TILE       = 16,
  parameter int unsigned GRID_COLS  = 20,
  parameter int unsigned GRID_ROWS  = 15
) (
  input logic             clk,
  input logic             reset_n,
  draw_scheduler_if.slave bus
);

  localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = FIFO_DEPTH[AW:0];
`ifdef DRAW_SCHED_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StGo, StRun, StDone} state_e;

  typedef struct packed {
    logic [3:0] id;
    logic [4:0] col;
    logic [3:0] row;
  } tile_t;

  state_e state_q, state_d;

  tile_t            fifo_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, wr_base;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop, flush, in_range, full;
  logic             tile_drop_q;
  tile_t            head;

  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_sel_q, pend_sel_d;

  logic             job_screen_q, job_screen_d;
  logic [1:0]       job_mem_sel_q, job_mem_sel_d;
  logic [3:0]       job_tile_q, job_tile_d;
  logic [4:0]       job_col_q, job_col_d;
  logic [3:0]       job_row_q, job_row_d;

  logic [8:0]       tile_x_base;
  logic [7:0]       tile_y_base;

  // Fullness uses the registered count, so a push while full loses even against a same-cycle pop.
  assign full     = (count_q == FULL_COUNT);
  assign in_range = (32'(bus.tile_col) < GRID_COLS) && (32'(bus.tile_row) < GRID_ROWS);
  assign push_ok  = bus.tile_req && !full && in_range;
  assign head     = fifo_q[rd_q];

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_sel_d    = pend_sel_q;
    job_screen_d  = job_screen_q;
    job_mem_sel_d = job_mem_sel_q;
    job_tile_d    = job_tile_q;
    job_col_d     = job_col_q;
    job_row_d     = job_row_q;
    pop           = 1'b0;
    flush         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          job_screen_d  = 1'b1;
          job_mem_sel_d = pend_sel_q;
          job_tile_d    = 4'd0;
          job_col_d     = 5'd0;
          job_row_d     = 4'd0;
          pend_valid_d  = 1'b0;
          flush         = FLUSH_EN;
          state_d       = StGo;
        end else if (count_q != '0) begin
          job_screen_d  = 1'b0;
          job_mem_sel_d = 2'b11;
          job_tile_d    = head.id;
          job_col_d     = head.col;
          job_row_d     = head.row;
          pop           = 1'b1;
          state_d       = StGo;
        end
      end
      StGo:   state_d = StRun;
      StRun:  if (bus.copy_finished) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A fresh request overrides the clear above so it is never lost.
    if (bus.screen_req && (bus.screen_sel != 2'b11)) begin
      pend_valid_d = 1'b1;
      pend_sel_d   = bus.screen_sel;
    end

    rd_d    = flush ? '0 : rd_q;
    wr_base = flush ? '0 : wr_q;
    count_d = flush ? '0 : count_q;
    if (pop) begin
      rd_d    = rd_q + AW'(1);
      count_d = count_d - (AW + 1)'(1);
    end
    wr_d = wr_base;
    if (push_ok) begin
      wr_d    = wr_base + AW'(1);
      count_d = count_d + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      rd_q          <= '0;
      wr_q          <= '0;
      count_q       <= '0;
      tile_drop_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_sel_q    <= 2'b00;
      job_screen_q  <= 1'b0;
      job_mem_sel_q <= 2'b00;
      job_tile_q    <= 4'd0;
      job_col_q     <= 5'd0;
      job_row_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      count_q       <= count_d;
      tile_drop_q   <= bus.tile_req && !push_ok;
      pend_valid_q  <= pend_valid_d;
      pend_sel_q    <= pend_sel_d;
      job_screen_q  <= job_screen_d;
      job_mem_sel_q <= job_mem_sel_d;
      job_tile_q    <= job_tile_d;
      job_col_q     <= job_col_d;
      job_row_q     <= job_row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_base] <= '{id: bus.tile_id, col: bus.tile_col, row: bus.tile_row};
    end
  end

  assign tile_x_base = 9'(job_col_q) * TILE[8:0];
  assign tile_y_base = 8'(job_row_q) * TILE[7:0];

  assign bus.tile_ready         = !full;
  assign bus.tile_drop          = tile_drop_q;
  assign bus.copy_go            = (state_q == StGo);
  assign bus.screen_ack         = (state_q == StGo) && job_screen_q;
  assign bus.done               = (state_q == StDone);
  assign bus.busy               = (state_q != StIdle);
  assign bus.copy_memory_select = job_mem_sel_q;
  assign bus.copy_tile_select   = job_tile_q;
  assign bus.vga_colour         = bus.copy_colour;
  assign bus.vga_plot           = bus.copy_write_en && (state_q == StRun);
  assign bus.vga_x = job_screen_q ? bus.copy_offset[8:0]
                                  : tile_x_base + {5'd0, bus.copy_offset[3:0]};
  assign bus.vga_y = job_screen_q ? bus.copy_offset[16:9]
                                  : tile_y_base + {4'd0, bus.copy_offset[7:4]};

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: a queue of expected jobs is filled as requests are driven
// and drained as copy_go strobes appear; the bench plays the copy engine.
module tb_draw_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic       scr;
    logic [1:0] mem;
    logic [3:0] tile;
  } exp_t;

  exp_t sb[$];

  draw_scheduler_if bus_if ();

  draw_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns in the copy_go cycle (or after the cycle budget runs out).
  task automatic wait_go(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus_if.copy_go !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_go"}, 32'(bus_if.copy_go), 32'd1);
    if (bus_if.copy_go === 1'b1) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_mem_sel"}, 32'(bus_if.copy_memory_select), 32'(e.mem));
        chk({tag, "_tile_sel"}, 32'(bus_if.copy_tile_select), 32'(e.tile));
        chk({tag, "_ack"}, 32'(bus_if.screen_ack), 32'(e.scr));
      end
    end
  endtask

  task automatic finish_job(input string tag, input bit map, input logic [16:0] off,
                            input int ex, input int ey);
    tick();
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
    chk({tag, "_go_once"}, 32'(bus_if.copy_go), 32'd0);
    if (map) begin
      bus_if.copy_offset   = off;
      bus_if.copy_write_en = 1'b1;
      bus_if.copy_colour   = 3'd6;
      #1;
      chk({tag, "_vga_x"}, 32'(bus_if.vga_x), 32'(ex));
      chk({tag, "_vga_y"}, 32'(bus_if.vga_y), 32'(ey));
      chk({tag, "_plot"}, 32'(bus_if.vga_plot), 32'd1);
      chk({tag, "_colour"}, 32'(bus_if.vga_colour), 32'd6);
      bus_if.copy_write_en = 1'b0;
    end
    bus_if.copy_finished = 1'b1;
    tick();
    bus_if.copy_finished = 1'b0;
    chk({tag, "_done"}, 32'(bus_if.done), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_gap_go"}, 32'(bus_if.copy_go), 32'd0);
  endtask

  task automatic tile(input logic [3:0] id, input logic [4:0] col, input logic [3:0] row);
    bus_if.tile_req = 1'b1;
    bus_if.tile_id  = id;
    bus_if.tile_col = col;
    bus_if.tile_row = row;
  endtask

  initial begin
    int seen;
    reset_n              = 1'b0;
    bus_if.screen_req    = 1'b0;
    bus_if.screen_sel    = 2'b00;
    bus_if.tile_req      = 1'b0;
    bus_if.tile_id       = 4'd0;
    bus_if.tile_col      = 5'd0;
    bus_if.tile_row      = 4'd0;
    bus_if.copy_offset   = 17'd0;
    bus_if.copy_colour   = 3'd0;
    bus_if.copy_write_en = 1'b0;
    bus_if.copy_finished = 1'b0;
    repeat (3) tick();

    chk("rst_go", 32'(bus_if.copy_go), 32'd0);
    chk("rst_mem", 32'(bus_if.copy_memory_select), 32'd0);
    chk("rst_tile", 32'(bus_if.copy_tile_select), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_ack", 32'(bus_if.screen_ack), 32'd0);
    chk("rst_drop", 32'(bus_if.tile_drop), 32'd0);
    chk("rst_ready", 32'(bus_if.tile_ready), 32'd1);
    reset_n = 1'b1;
    bus_if.copy_write_en = 1'b1;
    tick();
    chk("idle_plot", 32'(bus_if.vga_plot), 32'd0);
    bus_if.copy_write_en = 1'b0;

    // Single tile job: latency and pixel mapping.
    tile(4'd5, 5'd3, 4'd2);
    sb.push_back('{scr: 1'b0, mem: 2'b11, tile: 4'd5});
    tick();
    bus_if.tile_req = 1'b0;
    chk("lat_n1_go", 32'(bus_if.copy_go), 32'd0);
    tick();
    chk("lat_n2_go", 32'(bus_if.copy_go), 32'd1);
    wait_go("t1");
    finish_job("t1", 1'b1, 17'h000A7, 55, 42);

    // copy_finished while idle must not start or finish anything.
    bus_if.copy_finished = 1'b1;
    tick();
    bus_if.copy_finished = 1'b0;
    chk("idle_fin_busy", 32'(bus_if.busy), 32'd0);
    chk("idle_fin_done", 32'(bus_if.done), 32'd0);

    // Screen and tile together: screen first.
    bus_if.screen_req = 1'b1;
    bus_if.screen_sel = 2'b01;
    sb.push_back('{scr: 1'b1, mem: 2'b01, tile: 4'd0});
    sb.push_back('{scr: 1'b0, mem: 2'b11, tile: 4'd7});
`ifndef DRAW_SCHED_FLUSH_EN
    tile(4'd7, 5'd0, 4'd0);
    tick();
    bus_if.screen_req = 1'b0;
`else
    tick();
    bus_if.screen_req = 1'b0;
    tile(4'd7, 5'd0, 4'd0);
    tick();
`endif
    bus_if.tile_req = 1'b0;
    wait_go("s2");
    finish_job("s2", 1'b1, {8'd100, 9'd300}, 300, 100);
    wait_go("t2");
    finish_job("t2", 1'b0, 17'd0, 0, 0);

    // Fill the queue while a screen job runs, then overflow once.
    bus_if.screen_req = 1'b1;
    bus_if.screen_sel = 2'b00;
    sb.push_back('{scr: 1'b1, mem: 2'b00, tile: 4'd0});
    tick();
    bus_if.screen_req = 1'b0;
    wait_go("s3");
    for (int i = 0; i < 8; i++) begin
      tile(4'(i), 5'(i), 4'(i));
      sb.push_back('{scr: 1'b0, mem: 2'b11, tile: 4'(i)});
      tick();
    end
    bus_if.tile_req = 1'b0;
    chk("full_ready", 32'(bus_if.tile_ready), 32'd0);
    tile(4'd15, 5'd1, 4'd1);
    tick();
    bus_if.tile_req = 1'b0;
    chk("full_drop", 32'(bus_if.tile_drop), 32'd1);
    tick();
    chk("drop_pulse", 32'(bus_if.tile_drop), 32'd0);
    finish_job("s3", 1'b0, 17'd0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      wait_go("drain");
      finish_job("drain", 1'b0, 17'd0, 0, 0);
    end

    // Out-of-range cells and an invalid screen select start nothing.
    tile(4'd1, 5'd20, 4'd0);
    tick();
    bus_if.tile_req = 1'b0;
    chk("col_drop", 32'(bus_if.tile_drop), 32'd1);
    tile(4'd1, 5'd0, 4'd15);
    tick();
    bus_if.tile_req = 1'b0;
    chk("row_drop", 32'(bus_if.tile_drop), 32'd1);
    bus_if.screen_req = 1'b1;
    bus_if.screen_sel = 2'b11;
    tick();
    bus_if.screen_req = 1'b0;
    seen = 0;
    repeat (6) begin
      if (bus_if.copy_go === 1'b1) seen++;
      tick();
    end
    chk("oor_no_go", 32'(seen), 32'd0);

    // Corner tile, then two screen requests collapse into the last one.
    tile(4'd9, 5'd19, 4'd14);
    sb.push_back('{scr: 1'b0, mem: 2'b11, tile: 4'd9});
    tick();
    bus_if.tile_req = 1'b0;
    wait_go("t5");
    bus_if.screen_req = 1'b1;
    bus_if.screen_sel = 2'b00;
    tick();
    bus_if.screen_sel = 2'b10;
    sb.push_back('{scr: 1'b1, mem: 2'b10, tile: 4'd0});
    tick();
    bus_if.screen_req = 1'b0;
    finish_job("t5", 1'b1, 17'h000FF, 319, 239);
    wait_go("s5");
    finish_job("s5", 1'b0, 17'd0, 0, 0);
    seen = 0;
    repeat (5) begin
      if (bus_if.copy_go === 1'b1) seen++;
      tick();
    end
    chk("one_screen", 32'(seen), 32'd0);

    // Reset in the middle of a job discards everything queued.
    tile(4'd3, 5'd1, 4'd1);
    sb.push_back('{scr: 1'b0, mem: 2'b11, tile: 4'd3});
    tick();
    bus_if.tile_req = 1'b0;
    wait_go("t6");
    tick();
    tile(4'd4, 5'd2, 4'd2);
    tick();
    bus_if.tile_req   = 1'b0;
    bus_if.screen_req = 1'b1;
    bus_if.screen_sel = 2'b01;
    tick();
    bus_if.screen_req    = 1'b0;
    bus_if.copy_write_en = 1'b1;
    reset_n              = 1'b0;
    tick();
    chk("mid_go", 32'(bus_if.copy_go), 32'd0);
    chk("mid_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_done", 32'(bus_if.done), 32'd0);
    chk("mid_mem", 32'(bus_if.copy_memory_select), 32'd0);
    chk("mid_tile", 32'(bus_if.copy_tile_select), 32'd0);
    chk("mid_plot", 32'(bus_if.vga_plot), 32'd0);
    chk("mid_ready", 32'(bus_if.tile_ready), 32'd1);
    reset_n              = 1'b1;
    bus_if.copy_write_en = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (bus_if.copy_go === 1'b1 || bus_if.done === 1'b1) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
